apb_master: RTL
===============

Name: apb_master

Overview:
- Single-outstanding APB initiator that turns valid/ready command requests into APB transfers.
- Feeds the register-file slave, which exposes LEDs, USB FIFO, DAC config and DCE, from a local sequencer such as a USB command parser or boot-time init ROM, without the PS.
- Generates correct SETUP/ACCESS phasing, honours pready wait states, captures pslverr.
- Aborts hung transfers with a programmable timeout.

Parameters:
- ADDR_W, 40, APB address width.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles waiting for pready before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid && req_ready at a clk edge.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  write data.
- req_strb  in  4  write byte strobes.
- rsp_valid  out  1  response valid; held until taken.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  32  read data; 0 for writes and aborts.
- rsp_err  out  1  pslverr or timeout.
- rsp_timeout  out  1  transfer was aborted by the timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address, bits [1:0] forced to 0.
- pwdata  out  32  APB write data.
- pstrb  out  4  req_strb on writes, 4'h0 on reads.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error; sampled only when pready=1.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout all 0.
  - paddr, pwdata, pstrb, rsp_rdata all 0.
  - Timeout counter 0.
- Reset asserted mid-transfer: psel/penable drop immediately and the transfer is lost; no response is produced.
- req_ready = (state==IDLE). Combinational from state only, never from req_valid.
- IDLE:
  - On accept, register req_write/req_addr/req_wdata/req_strb onto pwrite/paddr/pwdata/pstrb and go to SETUP.
  - Outside a transfer, APB outputs hold their last values with psel=0.
- SETUP (exactly one cycle): psel=1, penable=0, then go to ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr/pwrite/pwdata/pstrb stable throughout.
  - On an edge with pready=1:
    - capture rsp_rdata = pwrite ? 0 : prdata, rsp_err = pslverr, rsp_timeout=0.
    - Drop psel/penable and go to RESP.
  - Otherwise increment the timeout counter.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with pready still 0:
    - abort with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - Drop psel/penable and go to RESP.
  - pready=1 on the same edge as the timeout threshold takes precedence: normal completion.
  - The counter clears on entry to SETUP.
- RESP:
  - rsp_valid=1; response fields stable until rsp_valid && rsp_ready, then return to IDLE.
  - No new request is accepted while in RESP (single outstanding).
- Latency with pready=1 on the first ACCESS cycle and rsp_ready=1:
  - accept edge T, SETUP at T+1, ACCESS at T+2, rsp_valid at T+3, req_ready at T+4.
  - Minimum 4 cycles per transfer.
  - Each wait state adds 1 cycle.
- pslverr and prdata are ignored whenever pready=0 or penable=0.

Test Plan:
- Write 0x00000003 to 0x000, strb F, pready tied 1:
  - psel rises 1 cycle after accept, penable 1 cycle later for exactly 1 cycle.
  - pstrb=F; rsp_valid, rsp_err=0 and rsp_rdata=0 come 3 cycles after accept.
- Read 0x010 with pready low for 3 ACCESS cycles, then prdata=0x00000001: penable high 4 cycles, paddr stable, rsp_rdata=0x00000001, pstrb=0.
- Write with pslverr=1 alongside pready=1 → rsp_err=1, rsp_timeout=0. A separate case with pslverr=1 while pready=0 must be ignored.
- TIMEOUT_CYCLES=8, pready stuck 0 → psel/penable drop after 8 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. A rerun with pready=1 exactly on the 8th cycle must complete normally.
- Back-to-back requests with rsp_ready held 0 for 5 cycles:
  - req_ready stays 0 and the response is stable throughout.
  - The second transfer's SETUP starts 2 cycles after the response handshake.
- Assert reset during ACCESS → psel/penable/rsp_valid go 0 asynchronously before the next edge; after release req_ready=1 and no stale response appears.

Source files
------------

// File: rtl/apb_master_if.sv
// Request/response handshake and APB bus signals of the apb_master initiator.
// The master modport faces the initiator; the slave modport faces the sequencer and APB target.
interface apb_master_if #(
  parameter int unsigned ADDR_W = 40
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_strb;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready,
    input  prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, rsp_ready,
    output prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: valid/ready command in, APB SETUP/ACCESS transfer out,
// response held until taken. Hung ACCESS phases are aborted after TIMEOUT_CYCLES.
module apb_master #(
  parameter int unsigned ADDR_W         = 40,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic          clk,
  input logic          reset,
  apb_master_if.master bus
);
  localparam int unsigned   CntW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam bit            TimeoutEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [31:0]       pwdata_q;
  logic [3:0]        pstrb_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            pwrite_q  <= bus.req_write;
            paddr_q   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            pwdata_q  <= bus.req_wdata;
            pstrb_q   <= bus.req_write ? bus.req_strb : 4'h0;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          state_q   <= StAccess;
        end
        StAccess: begin
          // A pready on the threshold edge wins over the abort.
          if (bus.pready) begin
            rsp_rdata_q   <= pwrite_q ? 32'h0 : bus.prdata;
            rsp_err_q     <= bus.pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= StResp;
          end else if (TimeoutEn && (cnt_q == CntLast)) begin
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule
